phase_cmd_scheduler: RTL and testbench

- Consumes the byte stream from the FT-chip receive path and decodes phase-write commands into a shadow phase bank.
- Commits the shadow bank to the active bank driving the transducer outputs, aligned to the emission-period sync pulse, so all channels change phase together.
- Sits between the FT receive FIFO interface and the per-channel transducer phase generators inside top.
- Reports protocol faults on a sticky read_error flag, which drives the board LED.

---
 rtl/phase_cmd_scheduler.sv | 164 ++++++++++++++++
 tb/tb_phase_cmd_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_cmd_scheduler.sv
// Decodes the FT receive byte stream into a shadow phase bank and commits it to
// the active bank on the emission-period sync pulse.
module phase_cmd_scheduler #(
  parameter int NUM_CHANNELS = 2,
  parameter int PHASE_W      = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            i_sys_clk,
  input  logic                            i_rst,
  input  logic [7:0]                      i_rx_data,
  input  logic                            i_rx_valid,
  output logic                            o_rx_ready,
  input  logic                            i_sync_pulse,
  output logic [NUM_CHANNELS*PHASE_W-1:0] o_phases,
  output logic                            o_commit_pulse,
  output logic                            o_read_error,
  output logic                            o_busy
);

  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]     OP_WRITE  = 8'h01;
  localparam logic [7:0]     OP_COMMIT = 8'h02;
  localparam logic [7:0]     OP_CLEAR  = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WAIT_SYNC
  } state_t;

  state_t                            r_state;
  state_t                            w_next_state;
  logic [7:0]                        r_addr;
  logic [CNT_W-1:0]                  r_cnt;
  logic [NUM_CHANNELS*PHASE_W-1:0]   r_shadow;
  logic [NUM_CHANNELS*PHASE_W-1:0]   r_phases;
  logic                              r_commit;
  logic                              r_error;
  logic                              w_accept;
  logic                              w_in_cmd;
  logic                              w_timeout;
  logic                              w_do_commit;
  logic [PHASE_W-1:0]                w_phase_byte;

  assign w_accept     = i_rx_valid & o_rx_ready;
  assign w_in_cmd     = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_timeout    = w_in_cmd && !w_accept && (r_cnt == CNT_LAST);
  assign w_do_commit  = (r_state == ST_WAIT_SYNC) && i_sync_pulse;
  assign w_phase_byte = PHASE_W'(i_rx_data);

  assign o_phases       = r_phases;
  assign o_commit_pulse = r_commit;
  assign o_read_error   = r_error;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_rx_data == OP_WRITE)) begin
          w_next_state = ST_ADDR;
        end else if (w_accept && (i_rx_data == OP_COMMIT)) begin
          w_next_state = ST_WAIT_SYNC;
        end
      end
      ST_ADDR: begin
        if (w_timeout) begin
          w_next_state = ST_IDLE;
        end else if (w_accept) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_timeout || w_accept) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (i_sync_pulse) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rx_ready = (r_state != ST_WAIT_SYNC);
    o_busy     = (r_state != ST_IDLE);
  end

  // Inter-byte timer: cleared outside a command and on every accepted byte.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_in_cmd && !w_accept && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_shadow <= '0;
      r_phases <= '0;
      r_commit <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_commit <= w_do_commit;
      if (w_do_commit) begin
        r_phases <= r_shadow;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (i_rx_data == OP_CLEAR) begin
              r_shadow <= '0;
              r_error  <= 1'b0;
            end else if ((i_rx_data != OP_WRITE) && (i_rx_data != OP_COMMIT)) begin
              r_error <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (w_accept) begin
            r_addr <= i_rx_data;
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            // Out-of-range addresses still consume the phase byte.
            if (int'(r_addr) < NUM_CHANNELS) begin
              for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (int'(r_addr) == i) begin
                  r_shadow[i*PHASE_W +: PHASE_W] <= w_phase_byte;
                end
              end
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_cmd_scheduler.sv
// Directed self-checking bench for phase_cmd_scheduler: reset, write/commit,
// same-cycle sync, bad input recovery, inter-byte timeout and backpressure.
module tb_phase_cmd_scheduler;

  localparam int NCH  = 2;
  localparam int PW   = 8;
  localparam int TOUT = 1024;

  logic              sysClk;
  logic              rst;
  logic [7:0]        rxData;
  logic              rxValid;
  logic              rxReady;
  logic              syncPulse;
  logic [NCH*PW-1:0] phases;
  logic              commitPulse;
  logic              readError;
  logic              busy;

  int checks;
  int errors;

  phase_cmd_scheduler #(
    .NUM_CHANNELS(NCH),
    .PHASE_W     (PW),
    .TIMEOUT     (TOUT)
  ) dut (
    .i_sys_clk     (sysClk),
    .i_rst         (rst),
    .i_rx_data     (rxData),
    .i_rx_valid    (rxValid),
    .o_rx_ready    (rxReady),
    .i_sync_pulse  (syncPulse),
    .o_phases      (phases),
    .o_commit_pulse(commitPulse),
    .o_read_error  (readError),
    .o_busy        (busy)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysClk);
      #1;
    end
  endtask

  // Presents one byte, holding rx_valid through any stall until it transfers.
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard   = 0;
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && guard < 100) begin
      tick(1);
      guard++;
    end
    checkOutput("ready_before_transfer", {31'd0, rxReady}, 32'd1);
    tick(1);
    rxValid = 1'b0;
  endtask

  task automatic doCommit(input string tag, input logic [NCH*PW-1:0] expPhases);
    applyStimulus(8'h02);
    checkOutput({tag, "_ready_low"}, {31'd0, rxReady}, 32'd0);
    tick(2);
    syncPulse = 1'b1;
    tick(1);
    syncPulse = 1'b0;
    checkOutput({tag, "_phases"}, 32'(phases), 32'(expPhases));
    checkOutput({tag, "_commit"}, {31'd0, commitPulse}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    rxData    = 8'h00;
    rxValid   = 1'b0;
    syncPulse = 1'b0;
    repeat (3) @(posedge sysClk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_phases", 32'(phases), 32'h0);
    checkOutput("rst_error", {31'd0, readError}, 32'd0);
    checkOutput("rst_ready", {31'd0, rxReady}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_commit", {31'd0, commitPulse}, 32'd0);

    $display("[TB] asynchronous reset mid-WRITE");
    applyStimulus(8'h7F);
    checkOutput("pre_rst_error", {31'd0, readError}, 32'd1);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_error", {31'd0, readError}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, rxReady}, 32'd1);
    checkOutput("async_rst_phases", 32'(phases), 32'h0);
    #1 rst = 1'b0;
    tick(1);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] write and commit");
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    checkOutput("wr0_idle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    checkOutput("wait_ready", {31'd0, rxReady}, 32'd0);
    checkOutput("wait_busy", {31'd0, busy}, 32'd1);
    tick(9);
    checkOutput("pre_sync_phases", 32'(phases), 32'h0);
    checkOutput("pre_sync_commit", {31'd0, commitPulse}, 32'd0);
    syncPulse = 1'b1;
    tick(1);
    syncPulse = 1'b0;
    checkOutput("sync_phases", 32'(phases), 32'hA55A);
    checkOutput("sync_commit", {31'd0, commitPulse}, 32'd1);
    checkOutput("sync_idle", {31'd0, busy}, 32'd0);
    tick(1);
    checkOutput("commit_one_cycle", {31'd0, commitPulse}, 32'd0);
    checkOutput("phases_hold", 32'(phases), 32'hA55A);

    $display("[TB] sync in same cycle as COMMIT");
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'hC3);
    syncPulse = 1'b1;
    applyStimulus(8'h02);
    syncPulse = 1'b0;
    checkOutput("same_cycle_phases", 32'(phases), 32'hA55A);
    checkOutput("same_cycle_commit", {31'd0, commitPulse}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("same_cycle_ready_low", {31'd0, rxReady}, 32'd0);
      tick(1);
    end
    syncPulse = 1'b1;
    tick(1);
    syncPulse = 1'b0;
    checkOutput("late_sync_phases", 32'(phases), 32'hA5C3);
    checkOutput("late_sync_commit", {31'd0, commitPulse}, 32'd1);

    $display("[TB] bad address, unknown opcode, clear");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h33);
    checkOutput("bad_addr_error", {31'd0, readError}, 32'd1);
    checkOutput("bad_addr_idle", {31'd0, busy}, 32'd0);
    doCommit("bad_addr_shadow", 16'hA5C3);
    applyStimulus(8'h7F);
    checkOutput("unknown_error_sticky", {31'd0, readError}, 32'd1);
    applyStimulus(8'h03);
    checkOutput("clear_error", {31'd0, readError}, 32'd0);
    checkOutput("clear_keeps_phases", 32'(phases), 32'hA5C3);
    doCommit("clear_shadow", 16'h0000);

    $display("[TB] inter-byte timeout");
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    tick(TOUT - 1);
    checkOutput("timeout_not_yet", {31'd0, readError}, 32'd0);
    checkOutput("timeout_still_busy", {31'd0, busy}, 32'd1);
    tick(1);
    checkOutput("timeout_error", {31'd0, readError}, 32'd1);
    checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    doCommit("after_timeout", 16'h0011);

    $display("[TB] backpressure across COMMIT");
    fork
      begin
        logic [7:0] stream [8];
        stream = '{8'h01, 8'h01, 8'h22, 8'h02, 8'h01, 8'h00, 8'h33, 8'h02};
        for (int i = 0; i < 8; i++) begin
          applyStimulus(stream[i]);
        end
      end
      begin
        logic [15:0] expBank [2];
        expBank = '{16'h2211, 16'h2233};
        for (int k = 0; k < 2; k++) begin
          int g;
          g = 0;
          while (rxReady && g < 50) begin
            tick(1);
            g++;
          end
          checkOutput("bp_stalled", {31'd0, rxReady}, 32'd0);
          tick(3);
          syncPulse = 1'b1;
          tick(1);
          syncPulse = 1'b0;
          checkOutput("bp_phases", 32'(phases), 32'(expBank[k]));
          checkOutput("bp_commit", {31'd0, commitPulse}, 32'd1);
        end
      end
    join
    tick(1);
    checkOutput("bp_final_phases", 32'(phases), 32'h2233);
    checkOutput("bp_final_idle", {31'd0, busy}, 32'd0);
    checkOutput("bp_final_error", {31'd0, readError}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
